// File: rtl/seq_disp_pkg.sv
// Shared types and the hex seven-segment lookup table for the hit display.
package seq_disp_pkg;

  typedef enum logic [0:0] {IDLE, LIT} led_state_t;

  // Segment patterns, gfedcba in bits 6:0, bit 7 always 0.
  localparam logic [7:0] SEG7_HEX [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h58, 8'h5E, 8'h79, 8'h71
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational 4-bit hex to seven-segment encoder.
module hex_to_seg7
  import seq_disp_pkg::*;
(
  input  logic [3:0] hex,
  output logic [7:0] seg7
);

  // Table lookup; every 4-bit value has an entry.
  always_comb begin
    seg7 = SEG7_HEX[hex];
  end

endmodule

// File: rtl/seq_hit_display.sv
// Counts rising edges of the sequence detector output, shows the count (or a
// frozen snapshot) on the seven-segment bus, and stretches each hit on an LED.
module seq_hit_display
  import seq_disp_pkg::*;
#(
  parameter int NBITS_COUNT = 4,
  parameter int NBITS_SEG   = 8,
  parameter int STRETCH     = 3
) (
  input  logic                   clk_2,
  input  logic                   reset,
  input  logic                   match_in,
  input  logic                   load,
  input  logic [NBITS_COUNT-1:0] data_in,
  input  logic                   freeze,
  output logic [NBITS_SEG-1:0]   seg,
  output logic [NBITS_COUNT-1:0] hit_count,
  output logic                   hit_led,
  output logic                   overflow
);

  localparam logic [3:0] TIMER_RELOAD = 4'(STRETCH - 1);

  logic                   match_q;
  logic                   hit;
  logic [NBITS_COUNT-1:0] count_next;
  logic                   overflow_next;
  logic [NBITS_COUNT-1:0] snap;
  logic [NBITS_COUNT-1:0] disp_val;
  logic [7:0]             seg_enc;
  led_state_t             state;
  logic [3:0]             timer;

  assign hit = match_in & ~match_q;

  // Previous detector level for edge detection.
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) match_q <= 1'b0;
    else       match_q <= match_in;
  end

  // Next counter/overflow value: load wins over a coincident hit.
  always_comb begin
    count_next    = hit_count;
    overflow_next = overflow;
    if (load) begin
      count_next    = data_in;
      overflow_next = 1'b0;
    end else if (hit) begin
      count_next = hit_count + NBITS_COUNT'(1);
      if (hit_count == '1) overflow_next = 1'b1;
    end
  end

  // Counter, sticky overflow and display snapshot registers.
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      hit_count <= '0;
      overflow  <= 1'b0;
      snap      <= '0;
    end else begin
      hit_count <= count_next;
      overflow  <= overflow_next;
      if (!freeze) snap <= count_next;
    end
  end

  // Value presented to the encoder: snapshot while frozen, live count otherwise.
  always_comb begin
    disp_val = freeze ? snap : hit_count;
  end

  hex_to_seg7 u_hex_to_seg7 (
    .hex  (disp_val[3:0]),
    .seg7 (seg_enc)
  );

  // Registered segment output.
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) seg <= NBITS_SEG'(SEG7_HEX[0]);
    else       seg <= NBITS_SEG'(seg_enc);
  end

  // Retriggerable LED stretcher: a hit in LIT reloads the timer.
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      timer <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hit) begin
            state <= LIT;
            timer <= TIMER_RELOAD;
          end
        end
        LIT: begin
          if (hit)              timer <= TIMER_RELOAD;
          else if (timer == '0) state <= IDLE;
          else                  timer <= timer - 4'd1;
        end
        default: begin
          state <= IDLE;
          timer <= '0;
        end
      endcase
    end
  end

  assign hit_led = (state == LIT);

endmodule

// File: tb/tb_seq_hit_display.sv
// Directed self-checking bench for seq_hit_display.
module tb_seq_hit_display;

  logic       clk_2 = 1'b0;
  logic       reset = 1'b1;
  logic       match_in = 1'b0;
  logic       load = 1'b0;
  logic [3:0] data_in = 4'h0;
  logic       freeze = 1'b0;
  logic [7:0] seg;
  logic [3:0] hit_count;
  logic       hit_led;
  logic       overflow;

  int unsigned checks = 0;
  int unsigned errors = 0;

  seq_hit_display #(
    .NBITS_COUNT (4),
    .NBITS_SEG   (8),
    .STRETCH     (3)
  ) dut (
    .clk_2     (clk_2),
    .reset     (reset),
    .match_in  (match_in),
    .load      (load),
    .data_in   (data_in),
    .freeze    (freeze),
    .seg       (seg),
    .hit_count (hit_count),
    .hit_led   (hit_led),
    .overflow  (overflow)
  );

  always #5 clk_2 = ~clk_2;

  task automatic tick();
    @(posedge clk_2);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] cnt, input logic [7:0] sg,
                           input logic led, input logic ovf);
    check({tag, ".count"}, 8'(hit_count), 8'(cnt));
    check({tag, ".seg"},   seg,           sg);
    check({tag, ".led"},   8'(hit_led),   8'(led));
    check({tag, ".ovf"},   8'(overflow),  8'(ovf));
  endtask

  initial begin
    // Reset then idle
    tick();
    tick();
    check_all("reset", 4'h0, 8'h3F, 1'b0, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_all("idle", 4'h0, 8'h3F, 1'b0, 1'b0);
    end

    // Level vs edge: high 5, low 2, high 1
    match_in = 1'b1;
    tick(); check_all("lvl_h1", 4'h1, 8'h3F, 1'b1, 1'b0);
    tick(); check_all("lvl_h2", 4'h1, 8'h06, 1'b1, 1'b0);
    tick(); check_all("lvl_h3", 4'h1, 8'h06, 1'b1, 1'b0);
    tick(); check_all("lvl_h4", 4'h1, 8'h06, 1'b0, 1'b0);
    tick(); check_all("lvl_h5", 4'h1, 8'h06, 1'b0, 1'b0);
    match_in = 1'b0;
    tick(); tick();
    check_all("lvl_low", 4'h1, 8'h06, 1'b0, 1'b0);
    match_in = 1'b1;
    tick(); check_all("lvl_r2a", 4'h2, 8'h06, 1'b1, 1'b0);
    match_in = 1'b0;
    tick(); check_all("lvl_r2b", 4'h2, 8'h5B, 1'b1, 1'b0);
    tick(); check_all("lvl_r2c", 4'h2, 8'h5B, 1'b1, 1'b0);
    tick(); check_all("lvl_r2d", 4'h2, 8'h5B, 1'b0, 1'b0);

    // Wrap 15 -> 0 sets overflow, load clears it
    load = 1'b1; data_in = 4'hF;
    tick(); check_all("ld_F", 4'hF, 8'h5B, 1'b0, 1'b0);
    load = 1'b0;
    tick(); check_all("ld_F_seg", 4'hF, 8'h71, 1'b0, 1'b0);
    match_in = 1'b1;
    tick(); check_all("wrap", 4'h0, 8'h71, 1'b1, 1'b1);
    match_in = 1'b0;
    tick(); check_all("wrap_seg", 4'h0, 8'h3F, 1'b1, 1'b1);
    tick(); tick();
    check_all("wrap_idle", 4'h0, 8'h3F, 1'b0, 1'b1);
    load = 1'b1; data_in = 4'h0;
    tick(); check_all("ovf_clr", 4'h0, 8'h3F, 1'b0, 1'b0);

    // Load and hit on the same edge: load wins, LED still pulses
    data_in = 4'hA; match_in = 1'b1;
    tick(); check_all("coll", 4'hA, 8'h3F, 1'b1, 1'b0);
    load = 1'b0; match_in = 1'b0;
    tick(); check_all("coll_seg", 4'hA, 8'h77, 1'b1, 1'b0);
    tick(); tick();
    check_all("coll_end", 4'hA, 8'h77, 1'b0, 1'b0);

    // Freeze: count to 3, freeze, 4 more hits, unfreeze
    load = 1'b1; data_in = 4'h0;
    tick();
    load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      match_in = 1'b1; tick();
      match_in = 1'b0; tick();
    end
    tick();
    check("frz_pre.count", 8'(hit_count), 8'h03);
    check("frz_pre.seg", seg, 8'h4F);
    freeze = 1'b1;
    for (int i = 0; i < 4; i++) begin
      match_in = 1'b1; tick();
      check("frz_hold_a.seg", seg, 8'h4F);
      match_in = 1'b0; tick();
      check("frz_hold_b.seg", seg, 8'h4F);
    end
    check("frz_cnt", 8'(hit_count), 8'h07);
    freeze = 1'b0;
    tick(); check("unfrz.seg", seg, 8'h07);

    // Retrigger: two hits 2 cycles apart give a 5-cycle LED pulse
    tick(); tick(); tick();
    check("retr_pre.led", 8'(hit_led), 8'h00);
    match_in = 1'b1; tick(); check("retr0.led", 8'(hit_led), 8'h01);
    match_in = 1'b0; tick(); check("retr1.led", 8'(hit_led), 8'h01);
    match_in = 1'b1; tick(); check("retr2.led", 8'(hit_led), 8'h01);
    match_in = 1'b0; tick(); check("retr3.led", 8'(hit_led), 8'h01);
    tick(); check("retr4.led", 8'(hit_led), 8'h01);
    tick(); check("retr5.led", 8'(hit_led), 8'h00);
    check_all("retr_end", 4'h9, 8'h6F, 1'b0, 1'b0);

    // Async reset mid-pulse, no clock edge in between
    match_in = 1'b1;
    tick(); check_all("pre_rst", 4'hA, 8'h6F, 1'b1, 1'b0);
    #2 reset = 1'b1;
    #1 check_all("async_rst", 4'h0, 8'h3F, 1'b0, 1'b0);

    // Release with match_in already high: first edge counts one hit
    #1 reset = 1'b0;
    tick(); check_all("rel_hi", 4'h1, 8'h3F, 1'b1, 1'b0);
    tick(); check_all("rel_hi_seg", 4'h1, 8'h06, 1'b1, 1'b0);
    match_in = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
